rd_scene_sequencer: RTL and testbench
=====================================

// Module: rd_scene_sequencer
// PURPOSE
//  Parametrised SDRAM read-window sequencer for the HDMI frame path. Selects one of
//  NUM_SCENES stored full-screen images by index and drives the read FIFO's enable and
//  begin/end word addresses. On a scene change it flushes the read FIFO with a multi-cycle
//  reset pulse and re-arms on the next frame-start point. Sits between the game state
//  logic and the SDRAM read-port controller, in the hdmi_clk domain.
// PARAMETERS
//  NUM_SCENES   4        number of image slots in SDRAM (>=2)
//  SCN_W        2        scene index width, must be >= clog2(NUM_SCENES)
//  ADDR_W       23       SDRAM word-address width
//  CNT_W        12       hcnt/vcnt width
//  FRAME_WORDS  786432   words per image; slot k spans [k*FRAME_WORDS, (k+1)*FRAME_WORDS)
//  SOF_H        100      hcnt value of the frame-start point
//  SOF_V        10       vcnt value of the frame-start point
//  FLUSH_CYC    4        sdram_rst_n low time in cycles (>=1)
// PORTS
//  hdmi_clk         in   1       pixel clock; the only clock
//  sys_rst_n        in   1       asynchronous, active-low reset
//  hcnt             in   CNT_W   horizontal pixel counter
//  vcnt             in   CNT_W   vertical line counter
//  scene_idx        in   SCN_W   requested image slot
//  scene_valid      in   1       1 = display scene_idx; 0 = stop reading
//  pix_req          in   1       read request from the pixel generator
//  sdram_rst_n      out  1       read-FIFO flush, active low
//  sdram_rden       out  1       read enable to the SDRAM read port
//  sdram_rd_b_addr  out  ADDR_W  read window begin address
//  sdram_rd_e_addr  out  ADDR_W  read window end address (exclusive)
//  active_scene     out  SCN_W   slot currently being streamed
//  switch_busy      out  1       1 while in FLUSH or WAIT_SOF
// BEHAVIOUR
//  - Reset: state=IDLE, sdram_rst_n=1, sdram_rden=0, both addresses=0, active_scene=0,
//    switch_busy=0. Reset asserted mid-stream returns everything to these values at once.
//  - sof: registered strobe, high for exactly one cycle, the cycle after hcnt==SOF_H &&
//    vcnt==SOF_V.
//  - req_ok = scene_valid && (scene_idx < NUM_SCENES). An out-of-range index is treated
//    as invalid.
//  - FSM:
//    IDLE:     on req_ok -> FLUSH, latching scene_idx into active_scene.
//    FLUSH:    sdram_rst_n=0 for exactly FLUSH_CYC cycles, then -> WAIT_SOF.
//              req_ok low -> IDLE.
//    WAIT_SOF: on sof -> STREAM. req_ok low -> IDLE. A new index -> FLUSH (relatch).
//    STREAM:   sdram_rden = pix_req, combinational gate with no added latency.
//              req_ok low -> IDLE. scene_idx != active_scene -> FLUSH (relatch).
//  - Priority:
//    - !req_ok beats index change, which beats sof.
//    - Index change in the same cycle as sof goes to FLUSH; streaming does not start.
//    - An index change during FLUSH restarts the flush counter with the new index.
//  - sdram_rden is 0 in every state except STREAM. sdram_rst_n is 1 outside FLUSH.
//  - Addresses are registered from active_scene and update the cycle after the latch,
//    so they are stable for the whole flush:
//    - b_addr = active_scene*FRAME_WORDS
//    - e_addr = b_addr + FRAME_WORDS
//    - Compute at ADDR_W+1 bits. NUM_SCENES*FRAME_WORDS must fit in ADDR_W; a
//      static check flags violation in simulation.
//  - In IDLE, addresses hold their last value. switch_busy = (state==FLUSH || state==WAIT_SOF).
//  - The same index deasserted and then reasserted always re-flushes; there is no
//    "already loaded" shortcut.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/FLUSH/WAIT_SOF/STREAM), a clog2 helper,
//    and the default frame geometry constants (FRAME_WORDS, SOF_H, SOF_V).
//  - One sub-module: rd_frame_strobe (CNT_W, SOF_H, SOF_V), a registered
//    position-match pulse, reusable for end-of-frame strobes.
//  - Top level holds the FSM, the flush counter (width clog2(FLUSH_CYC+1)), and the
//    address registers.
// TESTING
//  1 Reset, scene_valid=1, idx=1 -> sdram_rst_n low exactly 4 cycles; b=786432, e=1572864;
//    rden stays 0 until the cycle after hcnt=100/vcnt=10, then rden follows pix_req.
//  2 While streaming idx 1, switch to idx 2 -> rden drops next cycle; 4-cycle flush;
//    b=1572864, e=2359296; streaming resumes only at the next frame-start point.
//  3 Change idx in the same cycle sof fires -> FLUSH entered, no rden pulse that frame.
//  4 idx=3 with NUM_SCENES=3 -> IDLE, rden=0, sdram_rst_n=1; idx=0 -> flush, b=0, e=786432.
//  5 Drop scene_valid mid-FLUSH and mid-STREAM -> IDLE next cycle, sdram_rst_n=1, rden=0.
//  6 Assert sys_rst_n low mid-STREAM -> all outputs go to reset values asynchronously;
//    after release, nothing streams until a flush and a frame-start point.

Source files
------------

// File: rtl/rd_scene_sequencer_pkg.sv
// Shared FSM encoding, clog2 helper and default frame geometry for the scene read sequencer.
// Pure declarations; no logic, no latency, no flow control.
package rd_scene_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_STREAM   = 2'd3
  } seq_state_e;

  localparam int DEF_FRAME_WORDS = 786432;  // 1024x768 words per image
  localparam int DEF_SOF_H       = 100;
  localparam int DEF_SOF_V       = 10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_scene_sequencer_strobe.sv
// Registered one-cycle pulse when (hcnt, vcnt) hits a fixed raster position.
// Latency: pulse appears the cycle after the match; no backpressure.
module rd_frame_strobe
  import rd_scene_sequencer_pkg::*;
#(
  parameter int CNT_W = 12,
  parameter int SOF_H = DEF_SOF_H,
  parameter int SOF_V = DEF_SOF_V
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] hcnt_i,
  input  logic [CNT_W-1:0] vcnt_i,
  output logic             strobe_o
);

  logic strobe_q;
  logic strobe_d;

  assign strobe_d = (hcnt_i == CNT_W'(SOF_H)) && (vcnt_i == CNT_W'(SOF_V));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) strobe_q <= 1'b0;
    else         strobe_q <= strobe_d;
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/rd_scene_sequencer.sv
// Selects an SDRAM image slot, flushes the read FIFO on a change and re-arms at frame start.
// Latency: state/addresses registered, sdram_rden gates pix_req combinationally; no backpressure.
module rd_scene_sequencer
  import rd_scene_sequencer_pkg::*;
#(
  parameter int NUM_SCENES  = 4,
  parameter int SCN_W       = 2,
  parameter int ADDR_W      = 23,
  parameter int CNT_W       = 12,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int SOF_H       = DEF_SOF_H,
  parameter int SOF_V       = DEF_SOF_V,
  parameter int FLUSH_CYC   = 4
) (
  input  logic              hdmi_clk,
  input  logic              sys_rst_n,
  input  logic [CNT_W-1:0]  hcnt,
  input  logic [CNT_W-1:0]  vcnt,
  input  logic [SCN_W-1:0]  scene_idx,
  input  logic              scene_valid,
  input  logic              pix_req,
  output logic              sdram_rst_n,
  output logic              sdram_rden,
  output logic [ADDR_W-1:0] sdram_rd_b_addr,
  output logic [ADDR_W-1:0] sdram_rd_e_addr,
  output logic [SCN_W-1:0]  active_scene,
  output logic              switch_busy
);

  localparam int CW = (clog2(FLUSH_CYC + 1) < 1) ? 1 : clog2(FLUSH_CYC + 1);
  localparam logic [ADDR_W:0] FW = (ADDR_W + 1)'(FRAME_WORDS);
  localparam longint SPAN = longint'(NUM_SCENES) * longint'(FRAME_WORDS);

  if (SPAN >= (longint'(1) << ADDR_W)) begin : g_bad_geom
    $error("rd_scene_sequencer: NUM_SCENES*FRAME_WORDS does not fit in ADDR_W");
  end
  if (clog2(NUM_SCENES) > SCN_W) begin : g_bad_scn_w
    $error("rd_scene_sequencer: SCN_W too narrow for NUM_SCENES");
  end

  seq_state_e        state_q;
  logic [CW-1:0]     flush_cnt_q;
  logic [SCN_W-1:0]  active_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic [ADDR_W-1:0] e_addr_q;
  logic [ADDR_W:0]   b_addr_d;
  logic [ADDR_W:0]   e_addr_d;
  logic              sof;
  logic              req_ok;
  logic              idx_chg;
  logic              addr_ovf;

  rd_frame_strobe #(
    .CNT_W (CNT_W),
    .SOF_H (SOF_H),
    .SOF_V (SOF_V)
  ) u_sof (
    .clk_i    (hdmi_clk),
    .rst_ni   (sys_rst_n),
    .hcnt_i   (hcnt),
    .vcnt_i   (vcnt),
    .strobe_o (sof)
  );

  assign req_ok   = scene_valid && ({1'b0, scene_idx} < (SCN_W + 1)'(NUM_SCENES));
  assign idx_chg  = (scene_idx != active_q);
  assign b_addr_d = (ADDR_W + 1)'(active_q) * FW;
  assign e_addr_d = b_addr_d + FW;
  assign addr_ovf = b_addr_d[ADDR_W] | e_addr_d[ADDR_W];

  // Priority inside each state: !req_ok, then index change, then sof / flush completion.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      active_q    <= '0;
      b_addr_q    <= '0;
      e_addr_q    <= '0;
    end else begin
      if (state_q != ST_IDLE) begin
        b_addr_q <= b_addr_d[ADDR_W-1:0];
        e_addr_q <= e_addr_d[ADDR_W-1:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (req_ok) begin
            state_q     <= ST_FLUSH;
            active_q    <= scene_idx;
            flush_cnt_q <= '0;
          end
        end
        ST_FLUSH: begin
          if (!req_ok) begin
            state_q <= ST_IDLE;
          end else if (idx_chg) begin
            active_q    <= scene_idx;
            flush_cnt_q <= '0;
          end else if (flush_cnt_q == CW'(FLUSH_CYC - 1)) begin
            state_q <= ST_WAIT_SOF;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        ST_WAIT_SOF, ST_STREAM: begin
          if (!req_ok) begin
            state_q <= ST_IDLE;
          end else if (idx_chg) begin
            state_q     <= ST_FLUSH;
            active_q    <= scene_idx;
            flush_cnt_q <= '0;
          end else if (sof) begin
            state_q <= ST_STREAM;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assert property (@(posedge hdmi_clk) disable iff (!sys_rst_n) !addr_ovf);

  assign sdram_rst_n     = (state_q != ST_FLUSH);
  assign sdram_rden      = (state_q == ST_STREAM) && pix_req;
  assign switch_busy     = (state_q == ST_FLUSH) || (state_q == ST_WAIT_SOF);
  assign active_scene    = active_q;
  assign sdram_rd_b_addr = b_addr_q;
  assign sdram_rd_e_addr = e_addr_q;

endmodule

// File: tb/tb_rd_scene_sequencer.sv
// Directed bench for rd_scene_sequencer with a 3-slot configuration.
module tb_rd_scene_sequencer;

  localparam int ADDR_W = 23;
  localparam int CNT_W  = 12;
  localparam int SCN_W  = 2;

  logic              hdmi_clk;
  logic              sys_rst_n;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  vcnt;
  logic [SCN_W-1:0]  scene_idx;
  logic              scene_valid;
  logic              pix_req;
  logic              sdram_rst_n;
  logic              sdram_rden;
  logic [ADDR_W-1:0] sdram_rd_b_addr;
  logic [ADDR_W-1:0] sdram_rd_e_addr;
  logic [SCN_W-1:0]  active_scene;
  logic              switch_busy;

  int errors = 0;
  int checks = 0;
  int lo_cnt;
  int rd_cnt;

  rd_scene_sequencer #(
    .NUM_SCENES  (3),
    .SCN_W       (SCN_W),
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W),
    .FRAME_WORDS (786432),
    .SOF_H       (100),
    .SOF_V       (10),
    .FLUSH_CYC   (4)
  ) dut (
    .hdmi_clk        (hdmi_clk),
    .sys_rst_n       (sys_rst_n),
    .hcnt            (hcnt),
    .vcnt            (vcnt),
    .scene_idx       (scene_idx),
    .scene_valid     (scene_valid),
    .pix_req         (pix_req),
    .sdram_rst_n     (sdram_rst_n),
    .sdram_rden      (sdram_rden),
    .sdram_rd_b_addr (sdram_rd_b_addr),
    .sdram_rd_e_addr (sdram_rd_e_addr),
    .active_scene    (active_scene),
    .switch_busy     (switch_busy)
  );

  initial hdmi_clk = 1'b0;
  always #5 hdmi_clk = ~hdmi_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Eight cycles sampled at negedge: how many had the flush low and how many read.
  task automatic flush_window(output int lo, output int rd);
    lo = 0;
    rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge hdmi_clk);
      if (sdram_rst_n === 1'b0) lo++;
      if (sdram_rden !== 1'b0) rd++;
    end
  endtask

  // Present the frame-start position for one cycle; stream starts the cycle after the strobe.
  task automatic do_sof(input string tag);
    hcnt = 12'd100;
    vcnt = 12'd10;
    @(negedge hdmi_clk);
    hcnt = 12'd0;
    vcnt = 12'd0;
    chk({tag, "_rden_at_sof"}, 32'(sdram_rden), 32'd0);
    @(negedge hdmi_clk);
    chk({tag, "_rden_stream"}, 32'(sdram_rden), 32'd1);
    chk({tag, "_busy_stream"}, 32'(switch_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sys_rst_n   = 1'b0;
    hcnt        = '0;
    vcnt        = '0;
    scene_idx   = 2'd1;
    scene_valid = 1'b1;
    pix_req     = 1'b1;
    repeat (2) @(negedge hdmi_clk);

    // Reset values
    chk("rst_sdram_rst_n", 32'(sdram_rst_n), 32'd1);
    chk("rst_rden", 32'(sdram_rden), 32'd0);
    chk("rst_b_addr", 32'(sdram_rd_b_addr), 32'd0);
    chk("rst_e_addr", 32'(sdram_rd_e_addr), 32'd0);
    chk("rst_active", 32'(active_scene), 32'd0);
    chk("rst_busy", 32'(switch_busy), 32'd0);

    // 1: first selection of slot 1
    sys_rst_n = 1'b1;
    flush_window(lo_cnt, rd_cnt);
    chk("t1_flush_len", 32'(lo_cnt), 32'd4);
    chk("t1_rden_flush", 32'(rd_cnt), 32'd0);
    chk("t1_busy_wait", 32'(switch_busy), 32'd1);
    chk("t1_b_addr", 32'(sdram_rd_b_addr), 32'd786432);
    chk("t1_e_addr", 32'(sdram_rd_e_addr), 32'd1572864);
    chk("t1_active", 32'(active_scene), 32'd1);
    do_sof("t1");
    pix_req = 1'b0;
    #1 chk("t1_rden_gate_off", 32'(sdram_rden), 32'd0);
    pix_req = 1'b1;
    #1 chk("t1_rden_gate_on", 32'(sdram_rden), 32'd1);

    // 2: switch to slot 2 while streaming
    scene_idx = 2'd2;
    @(negedge hdmi_clk);
    chk("t2_rden_drop", 32'(sdram_rden), 32'd0);
    chk("t2_flush_low", 32'(sdram_rst_n), 32'd0);
    chk("t2_active", 32'(active_scene), 32'd2);
    chk("t2_b_addr_lag", 32'(sdram_rd_b_addr), 32'd786432);
    flush_window(lo_cnt, rd_cnt);
    chk("t2_flush_rest", 32'(lo_cnt), 32'd3);
    chk("t2_rden_flush", 32'(rd_cnt), 32'd0);
    chk("t2_b_addr", 32'(sdram_rd_b_addr), 32'd1572864);
    chk("t2_e_addr", 32'(sdram_rd_e_addr), 32'd2359296);
    do_sof("t2");

    // 3: index change coincides with the frame-start strobe
    hcnt = 12'd100;
    vcnt = 12'd10;
    @(negedge hdmi_clk);
    hcnt      = 12'd0;
    vcnt      = 12'd0;
    scene_idx = 2'd1;
    @(negedge hdmi_clk);
    chk("t3_rden", 32'(sdram_rden), 32'd0);
    chk("t3_flush_low", 32'(sdram_rst_n), 32'd0);
    flush_window(lo_cnt, rd_cnt);
    chk("t3_flush_rest", 32'(lo_cnt), 32'd3);
    chk("t3_no_rden", 32'(rd_cnt), 32'd0);
    chk("t3_busy", 32'(switch_busy), 32'd1);
    chk("t3_active", 32'(active_scene), 32'd1);

    // 4: out-of-range index, then slot 0
    scene_idx = 2'd3;
    @(negedge hdmi_clk);
    chk("t4_oor_rden", 32'(sdram_rden), 32'd0);
    chk("t4_oor_rst_n", 32'(sdram_rst_n), 32'd1);
    chk("t4_oor_busy", 32'(switch_busy), 32'd0);
    chk("t4_oor_active", 32'(active_scene), 32'd1);
    @(negedge hdmi_clk);
    chk("t4_oor_b_hold", 32'(sdram_rd_b_addr), 32'd786432);
    chk("t4_oor_still_idle", 32'(switch_busy), 32'd0);
    scene_idx = 2'd0;
    flush_window(lo_cnt, rd_cnt);
    chk("t4_flush_len", 32'(lo_cnt), 32'd4);
    chk("t4_b_addr", 32'(sdram_rd_b_addr), 32'd0);
    chk("t4_e_addr", 32'(sdram_rd_e_addr), 32'd786432);
    chk("t4_active", 32'(active_scene), 32'd0);
    do_sof("t4");

    // 5: drop valid mid-STREAM, re-flush of same index, drop valid mid-FLUSH
    scene_valid = 1'b0;
    @(negedge hdmi_clk);
    chk("t5_stream_drop_rden", 32'(sdram_rden), 32'd0);
    chk("t5_stream_drop_busy", 32'(switch_busy), 32'd0);
    chk("t5_stream_drop_rst_n", 32'(sdram_rst_n), 32'd1);
    scene_valid = 1'b1;
    @(negedge hdmi_clk);
    chk("t5_reflush", 32'(sdram_rst_n), 32'd0);
    scene_valid = 1'b0;
    @(negedge hdmi_clk);
    chk("t5_flush_drop_rst_n", 32'(sdram_rst_n), 32'd1);
    chk("t5_flush_drop_busy", 32'(switch_busy), 32'd0);
    chk("t5_flush_drop_rden", 32'(sdram_rden), 32'd0);
    scene_valid = 1'b1;
    flush_window(lo_cnt, rd_cnt);
    chk("t5_flush_len", 32'(lo_cnt), 32'd4);
    do_sof("t5");

    // 6: asynchronous reset mid-stream
    @(negedge hdmi_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rden", 32'(sdram_rden), 32'd0);
    chk("t6_rst_n", 32'(sdram_rst_n), 32'd1);
    chk("t6_b_addr", 32'(sdram_rd_b_addr), 32'd0);
    chk("t6_e_addr", 32'(sdram_rd_e_addr), 32'd0);
    chk("t6_active", 32'(active_scene), 32'd0);
    chk("t6_busy", 32'(switch_busy), 32'd0);
    scene_idx = 2'd2;
    @(negedge hdmi_clk);
    sys_rst_n = 1'b1;
    flush_window(lo_cnt, rd_cnt);
    chk("t6_flush_len", 32'(lo_cnt), 32'd4);
    chk("t6_no_rden", 32'(rd_cnt), 32'd0);
    chk("t6_b_addr_after", 32'(sdram_rd_b_addr), 32'd1572864);
    do_sof("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
